big_tile_reader: RTL and testbench

Read-side client of the BIG tile-map memory (2048 x 6-bit; the initializer writes it through `big_addr`/`big_data`/`big_we`). It accepts pixel coordinates from the display timing chain and converts them to BIG addresses. It issues synchronous reads and returns the 6-bit tile index with the in-tile pixel offset, in order, to the glyph renderer. A one-entry last-address cache suppresses redundant reads. A 4-entry output FIFO decouples renderer backpressure.

---
 rtl/big_tile_reader.sv | 138 +++++++++++++
 tb/tb_big_tile_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_tile_reader.sv
// Read-side client of the BIG tile map: turns pixel coordinates into tile-map reads
// and returns tile index plus in-tile offset in order, through a 4-entry output FIFO.
module big_tile_reader #(
  parameter int TILE_LOG2     = 3,
  parameter int MAP_COLS_LOG2 = 6,
  parameter int MAP_ROWS_LOG2 = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [9:0]                             pix_x,
  input  logic [9:0]                             pix_y,
  input  logic                                   cache_inval,
  output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] big_addr,
  output logic                                   big_re,
  input  logic [5:0]                             big_data,
  output logic                                   tile_valid,
  input  logic                                   tile_ready,
  output logic [5:0]                             tile_idx,
  output logic [TILE_LOG2-1:0]                   tile_px,
  output logic [TILE_LOG2-1:0]                   tile_py,
  output logic                                   tile_oob
);

  localparam int AW = MAP_ROWS_LOG2 + MAP_COLS_LOG2;
  localparam int EW = 1 + 6 + 2 * TILE_LOG2;

  typedef enum logic [1:0] {KIND_MISS, KIND_HIT, KIND_OOB} kind_e;

  logic [9:0]           col, row;
  logic [AW-1:0]        addr;
  logic                 in_map, hit, accept;
  kind_e                kind;

  logic                 s1_valid, s2_valid;
  kind_e                s1_kind, s2_kind;
  logic [TILE_LOG2-1:0] s1_px, s1_py, s2_px, s2_py;
  logic [5:0]           s2_idx;

  logic                 cache_valid;
  logic [AW-1:0]        cache_addr;
  logic [5:0]           cache_data;

  logic [EW-1:0]        fifo_mem [4];
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           fifo_count, occupancy;
  logic                 push, pop;
  logic [EW-1:0]        head;

  assign col    = pix_x >> TILE_LOG2;
  assign row    = pix_y >> TILE_LOG2;
  assign in_map = (col < 10'(1 << MAP_COLS_LOG2)) && (row < 10'(1 << MAP_ROWS_LOG2));
  assign addr   = {row[MAP_ROWS_LOG2-1:0], col[MAP_COLS_LOG2-1:0]};
  // A coincident invalidate forces this accept to re-read the memory.
  assign hit    = cache_valid && !cache_inval && (addr == cache_addr);

  always_comb begin
    kind = KIND_MISS;
    if (!in_map) kind = KIND_OOB;
    else if (hit) kind = KIND_HIT;
  end

  // Credit counts every entry in flight, so the FIFO can never overflow.
  assign occupancy = fifo_count + 3'(s1_valid) + 3'(s2_valid);
  assign pix_ready = occupancy < 3'd4;
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    s2_idx = 6'd0;
    case (s2_kind)
      KIND_MISS: s2_idx = big_data;
      KIND_HIT:  s2_idx = cache_data;
      default:   s2_idx = 6'd0;
    endcase
  end

  assign push       = s2_valid;
  assign tile_valid = fifo_count != 3'd0;
  assign pop        = tile_valid && tile_ready;
  assign head       = fifo_mem[rd_ptr];
  assign {tile_oob, tile_idx, tile_px, tile_py} = tile_valid ? head : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      big_re      <= 1'b0;
      big_addr    <= '0;
      s1_valid    <= 1'b0;
      s1_kind     <= KIND_MISS;
      s1_px       <= '0;
      s1_py       <= '0;
      s2_valid    <= 1'b0;
      s2_kind     <= KIND_MISS;
      s2_px       <= '0;
      s2_py       <= '0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      big_re   <= 1'b0;
      s1_valid <= accept;
      if (accept) begin
        s1_kind <= kind;
        s1_px   <= pix_x[TILE_LOG2-1:0];
        s1_py   <= pix_y[TILE_LOG2-1:0];
        if (kind == KIND_MISS) begin
          big_re     <= 1'b1;
          big_addr   <= addr;
          cache_addr <= addr;
        end
      end
      if (accept && kind == KIND_MISS) cache_valid <= 1'b1;
      else if (cache_inval) cache_valid <= 1'b0;

      s2_valid <= s1_valid;
      s2_kind  <= s1_kind;
      s2_px    <= s1_px;
      s2_py    <= s1_py;
      if (s2_valid && s2_kind == KIND_MISS) cache_data <= big_data;

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s2_kind == KIND_OOB, s2_idx, s2_px, s2_py};
  end

endmodule

// File: tb/tb_big_tile_reader.sv
// Randomized and directed bench for big_tile_reader against a scoreboard model
// that derives every tile from the map contents and a one-entry cache rule.
module tb_big_tile_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, pix_ready;
  logic [9:0]  pix_x, pix_y;
  logic        cache_inval;
  logic [10:0] big_addr;
  logic        big_re;
  logic [5:0]  big_data = 6'd0;
  logic        tile_valid, tile_ready;
  logic [5:0]  tile_idx;
  logic [2:0]  tile_px, tile_py;
  logic        tile_oob;

  big_tile_reader dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .cache_inval(cache_inval),
    .big_addr(big_addr), .big_re(big_re), .big_data(big_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_idx(tile_idx),
    .tile_px(tile_px), .tile_py(tile_py), .tile_oob(tile_oob)
  );

  always #5 clk = ~clk;

  logic [5:0] big_mem [0:2047];
  always @(posedge clk) if (big_re) big_data <= big_mem[big_addr];

  typedef struct {
    logic [12:0] val;
    int          acc_edge;
  } exp_t;

  exp_t        exp_q [$];
  logic [10:0] rd_q [$];
  bit          m_cvalid;
  logic [10:0] m_caddr;
  logic [5:0]  m_cdata;

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int n_reads = 0, n_acc = 0, n_pop = 0;
  logic [5:0] last_idx = 6'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: observe mid-cycle, update the model with the handshakes of the
  // coming edge, then return just after that edge.
  task automatic step(output bit acc);
    exp_t        e;
    logic [10:0] a;
    logic [5:0]  idx;
    int          col, row;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      exp_q.delete();
      rd_q.delete();
      m_cvalid = 1'b0;
    end else begin
      check("pix_ready", 32'(pix_ready), 32'(exp_q.size() < 4));
      check("tile_valid", 32'(tile_valid),
            32'(exp_q.size() > 0 && exp_q[0].acc_edge + 2 <= cyc));
      if (big_re) begin
        n_reads++;
        if (rd_q.size() == 0) check("read_unexpected", 32'(big_re), 32'd0);
        else begin
          a = rd_q.pop_front();
          check("read_addr", 32'(big_addr), 32'(a));
        end
      end
      if (tile_valid && tile_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'(tile_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("tile", 32'({tile_oob, tile_idx, tile_px, tile_py}), 32'(e.val));
          $display("tile %0d: idx=%0d px=%0d py=%0d oob=%0d", n_pop, tile_idx, tile_px,
                   tile_py, tile_oob);
          last_idx = tile_idx;
          n_pop++;
        end
      end
      acc = pix_valid && pix_ready;
      if (acc) begin
        n_acc++;
        col = int'(pix_x) / 8;
        row = int'(pix_y) / 8;
        if (col >= 64 || row >= 32) begin
          idx = 6'd0;
          if (cache_inval) m_cvalid = 1'b0;
        end else begin
          a = 11'(row * 64 + col);
          if (m_cvalid && !cache_inval && m_caddr == a) idx = m_cdata;
          else begin
            idx = big_mem[a];
            rd_q.push_back(a);
            m_cvalid = 1'b1;
            m_caddr  = a;
            m_cdata  = idx;
          end
        end
        e.val      = {(col >= 64 || row >= 32), idx, pix_x[2:0], pix_y[2:0]};
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
      end else if (cache_inval) begin
        m_cvalid = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input int x, input int y);
    bit acc;
    acc = 1'b0;
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) step(acc);
    check("send_timeout", 32'(acc), 32'd1);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(acc);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_inval();
    bit acc;
    cache_inval = 1'b1;
    step(acc);
    cache_inval = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int r0, a0;
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    cache_inval = 1'b0;
    tile_ready = 1'b0;
    for (int a = 0; a < 2048; a++) big_mem[a] = 6'(a);

    #3;
    check("rst_ready", 32'(pix_ready), 32'd1);
    check("rst_outs", 32'({big_re, big_addr, tile_valid, tile_idx, tile_px, tile_py, tile_oob}), 32'd0);
    repeat (3) step(acc);
    rst = 1'b1;

    // Streaming through two tiles of row 0.
    tile_ready = 1'b1;
    r0 = n_reads;
    a0 = n_pop;
    for (int x = 0; x < 16; x++) send(x, 0);
    drain();
    check("t1_reads", 32'(n_reads - r0), 32'd2);
    check("t1_pops", 32'(n_pop - a0), 32'd16);

    // Off-map pixel leaves the cache alone.
    r0 = n_reads;
    send(600, 10);
    send(8, 0);
    drain();
    check("t2_reads", 32'(n_reads - r0), 32'd0);

    // Invalidate between two pixels of one tile picks up changed contents.
    r0 = n_reads;
    send(40, 40);
    drain();
    big_mem[325] = 6'h2a;
    pulse_inval();
    send(41, 40);
    drain();
    check("t3_reads", 32'(n_reads - r0), 32'd2);
    check("t3_new_idx", 32'(last_idx), 32'h2a);

    // Backpressure: four credits, then stall.
    tile_ready = 1'b0;
    a0 = n_acc;
    pix_x = 10'd100;
    pix_y = 10'd100;
    pix_valid = 1'b1;
    repeat (10) step(acc);
    check("t4_accepts", 32'(n_acc - a0), 32'd4);
    check("t4_ready_low", 32'(pix_ready), 32'd0);
    pix_valid = 1'b0;
    tile_ready = 1'b1;
    step(acc);
    check("t4_resume", 32'(pix_ready), 32'd1);
    drain();

    // Mixed hit/miss/OOB ordering.
    r0 = n_reads;
    send(0, 0);
    send(8, 0);
    send(600, 0);
    send(0, 0);
    drain();
    check("t5_reads", 32'(n_reads - r0), 32'd3);

    // Random traffic over a small window so hits, misses and OOB all occur.
    for (int a = 0; a < 2048; a++) big_mem[a] = 6'($urandom);
    for (int i = 0; i < 400; i++) begin
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_x       = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(512, 1023))
                                                : 10'($urandom_range(0, 79));
      pix_y       = 10'($urandom_range(250, 265));
      cache_inval = ($urandom_range(0, 9) == 0);
      tile_ready  = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    pix_valid = 1'b0;
    cache_inval = 1'b0;
    tile_ready = 1'b1;
    drain();
    check("rand_reads_left", 32'(rd_q.size()), 32'd0);

    // Reset with three entries buffered.
    tile_ready = 1'b0;
    send(16, 8);
    send(24, 8);
    send(32, 8);
    repeat (3) step(acc);
    check("t6_buffered", 32'(tile_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_outs", 32'({big_re, big_addr, tile_valid, tile_idx, tile_px, tile_py, tile_oob}), 32'd0);
    check("t6_rst_ready", 32'(pix_ready), 32'd1);
    repeat (2) step(acc);
    rst = 1'b1;
    tile_ready = 1'b1;
    r0 = n_reads;
    send(16, 8);
    drain();
    check("t6_first_miss", 32'(n_reads - r0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
